// File: rtl/median_frame_sequencer.sv
// Frame sequencer for the RGB median filter: streams source pixels to the
// filter under valid/stall and captures median results into the destination RAM.
module median_frame_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 229,
  parameter int IMG_HEIGHT  = 229,
  parameter int WINDOW_SIZE = 5,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    src_rd_en,
  output logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [3*DATA_WIDTH-1:0] src_rd_data,
  output logic [3*DATA_WIDTH-1:0] filt_pixel,
  output logic                    filt_valid,
  input  logic                    filt_stall,
  output logic                    filt_more_pixels,
  input  logic                    filt_out_valid,
  input  logic [3*DATA_WIDTH-1:0] filt_median,
  output logic                    dst_wr_en,
  output logic [ADDR_WIDTH-1:0]   dst_addr,
  output logic [3*DATA_WIDTH-1:0] dst_wr_data,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_overflow
);

  localparam int PAD         = WINDOW_SIZE / 2;
  localparam int NUM_PIXELS  = IMG_WIDTH * IMG_HEIGHT;
  localparam int MAX_WINDOWS = (IMG_HEIGHT - 2*PAD) * (IMG_WIDTH - 2*PAD);
  localparam int PW          = 3 * DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_WIN  = ADDR_WIDTH'(MAX_WINDOWS);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, PRESENT, DRAIN, DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] out_count;
  logic [PW-1:0]         pix_reg;
  logic                  capture;

  assign capture    = (state != IDLE) && (state != DONE);
  assign src_addr   = rd_ptr;
  assign filt_pixel = pix_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      rd_ptr           <= '0;
      out_count        <= '0;
      pix_reg          <= '0;
      src_rd_en        <= 1'b0;
      filt_valid       <= 1'b0;
      filt_more_pixels <= 1'b0;
      dst_wr_en        <= 1'b0;
      dst_addr         <= '0;
      dst_wr_data      <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      err_overflow     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      dst_wr_en  <= 1'b0;
      if (state != IDLE && abort) begin
        // a result captured this cycle is dropped with the frame
        state            <= IDLE;
        src_rd_en        <= 1'b0;
        filt_valid       <= 1'b0;
        filt_more_pixels <= 1'b0;
        busy             <= 1'b0;
      end else begin
        if (capture && filt_out_valid) begin
          if (out_count < MAX_WIN) begin
            dst_wr_en   <= 1'b1;
            dst_addr    <= out_count;
            dst_wr_data <= filt_median;
            out_count   <= out_count + 1'b1;
          end else begin
            err_overflow <= 1'b1;
          end
        end
        unique case (state)
          IDLE: if (start && !abort) begin
            state            <= FETCH;
            rd_ptr           <= '0;
            out_count        <= '0;
            err_overflow     <= 1'b0;
            src_rd_en        <= 1'b1;
            filt_more_pixels <= 1'b1;
            busy             <= 1'b1;
          end
          FETCH: begin
            state     <= LOAD;
            src_rd_en <= 1'b0;
          end
          LOAD: begin
            state      <= PRESENT;
            pix_reg    <= src_rd_data;
            filt_valid <= 1'b1;
          end
          PRESENT: if (!filt_stall) begin
            filt_valid <= 1'b0;
            if (rd_ptr == LAST_PIX) begin
              state            <= DRAIN;
              filt_more_pixels <= 1'b0;
            end else begin
              state     <= FETCH;
              rd_ptr    <= rd_ptr + 1'b1;
              src_rd_en <= 1'b1;
            end
          end
          DRAIN: if (out_count == MAX_WIN && !dst_wr_en) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Bench for median_frame_sequencer: RAM and filter models, frame scoreboard,
// table of frame scenarios plus abort/reset/start corner sequences.
module tb_median_frame_sequencer;

  localparam int DW = 8, W = 7, H = 7, WIN = 3, AW = 16;
  localparam int PAD = WIN / 2;
  localparam int NP = W * H;
  localparam int MAXW = (H - 2*PAD) * (W - 2*PAD);
  localparam int EXTRA_PIX = 43;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic src_rd_en;
  logic [AW-1:0] src_addr;
  logic [3*DW-1:0] src_rd_data;
  logic [3*DW-1:0] filt_pixel;
  logic filt_valid, filt_stall, filt_more_pixels;
  logic filt_out_valid;
  logic [3*DW-1:0] filt_median;
  logic dst_wr_en;
  logic [AW-1:0] dst_addr;
  logic [3*DW-1:0] dst_wr_data;
  logic busy, frame_done, err_overflow;

  median_frame_sequencer #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .WINDOW_SIZE(WIN), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_rd_en(src_rd_en), .src_addr(src_addr),
    .src_rd_data(src_rd_data),
    .filt_pixel(filt_pixel), .filt_valid(filt_valid),
    .filt_stall(filt_stall),
    .filt_more_pixels(filt_more_pixels),
    .filt_out_valid(filt_out_valid),
    .filt_median(filt_median),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr),
    .dst_wr_data(dst_wr_data),
    .busy(busy), .frame_done(frame_done),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  typedef struct {
    int    stall_pix;
    int    stall_len;
    bit    rnd;
    bit    extra;
    bit    exp_err;
    string name;
  } vec_t;

  logic [23:0] mem [NP];
  logic [23:0] acc_q[$];
  logic [23:0] em_q[$];
  wr_t         act_w[$];
  vec_t        vecs[5];

  int acc_n, done_cnt, stall_done;
  int stall_pix = -1;
  int stall_len = 0;
  bit rnd_stall, extra_en, pend_v;
  logic [23:0] pend_d;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // per-channel median of the WIN x WIN window centred at (cr,cc)
  function automatic logic [23:0] med_win(input int cr, input int cc);
    logic [23:0] res;
    int q[$];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      q = {};
      for (int dr = -PAD; dr <= PAD; dr++)
        for (int dc = -PAD; dc <= PAD; dc++)
          q.push_back(int'(mem[(cr+dr)*W + cc + dc][8*ch +: 8]));
      q.sort();
      res[8*ch +: 8] = 8'(q[WIN*WIN/2]);
    end
    return res;
  endfunction

  task automatic accept_pixel();
    int r, c;
    r = acc_n / W;
    c = acc_n % W;
    acc_q.push_back(filt_pixel);
    if (extra_en && acc_n == EXTRA_PIX) begin
      pend_v = 1'b1;
      pend_d = 24'hEEEEEE;
      em_q.push_back(pend_d);
    end else if (r >= WIN-1 && c >= WIN-1) begin
      pend_v = 1'b1;
      pend_d = med_win(r - PAD, c - PAD);
      em_q.push_back(pend_d);
    end
    acc_n++;
  endtask

  // source RAM, filter model and write monitor, all on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (src_rd_en && src_addr < NP) src_rd_data = mem[src_addr];
      filt_out_valid = pend_v;
      filt_median    = pend_d;
      pend_v         = 1'b0;
      filt_stall     = 1'b0;
      if (filt_valid && !rst) begin
        if (acc_n == stall_pix && stall_done < stall_len) begin
          filt_stall = 1'b1;
          stall_done++;
          check("stall_hold", filt_pixel, mem[acc_n]);
          check("stall_no_rd", src_rd_en, 0);
        end else if (rnd_stall && $urandom_range(3) == 0) begin
          filt_stall = 1'b1;
        end
      end
      if (filt_valid && !filt_stall && !abort && !rst) accept_pixel();
      if (dst_wr_en) act_w.push_back('{dst_addr, dst_wr_data});
      if (frame_done) done_cnt++;
    end
  end

  task automatic set_mem(input bit rnd);
    for (int i = 0; i < NP; i++)
      mem[i] = rnd ? 24'($urandom) : {8'(i), 8'(i), 8'(i)};
  endtask

  task automatic launch(input string tag);
    acc_q.delete();
    em_q.delete();
    act_w.delete();
    acc_n = 0;
    stall_done = 0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_fetch"},
          {src_rd_en, busy, filt_more_pixels, filt_valid}, 4'b1110);
    check({tag, "_addr0"}, src_addr, 0);
    @(posedge clk); #1;
    check({tag, "_load"}, {src_rd_en, filt_valid}, 2'b00);
    @(posedge clk); #1;
    check({tag, "_present"}, filt_valid, 1);
    check({tag, "_pix0"}, filt_pixel, mem[0]);
  endtask

  task automatic finish_frame(input string tag, input bit exp_err);
    bit seen;
    int bad, n;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      seen = frame_done;
    end
    check({tag, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
    check({tag, "_idle"}, {busy, frame_done, filt_more_pixels}, 3'b000);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_err"}, err_overflow, exp_err);
    bad = (acc_q.size() != NP) ? 1 : 0;
    for (int i = 0; i < acc_q.size(); i++)
      if (i >= NP || acc_q[i] !== mem[i]) bad++;
    check({tag, "_pix_order_bad"}, bad, 0);
    n = (em_q.size() < MAXW) ? em_q.size() : MAXW;
    check({tag, "_wr_count"}, act_w.size(), n);
    bad = 0;
    for (int i = 0; i < act_w.size(); i++)
      if (i >= n || act_w[i].addr !== AW'(i) || act_w[i].data !== em_q[i])
        bad++;
    check({tag, "_wr_bad"}, bad, 0);
  endtask

  task automatic wait_cond(input string tag, input int what);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #1;
      unique case (what)
        0: hit = filt_valid && acc_n == 5;
        1: hit = filt_valid && filt_pixel == mem[20];
        default: hit = busy && !filt_more_pixels && !frame_done;
      endcase
    end
    check({tag, "_reached"}, hit, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    vecs[0] = '{-1, 0, 1'b0, 1'b0, 1'b0, "ramp"};
    vecs[1] = '{10, 4, 1'b0, 1'b0, 1'b0, "stall10"};
    vecs[2] = '{-1, 0, 1'b0, 1'b1, 1'b1, "overflow"};
    vecs[3] = '{-1, 0, 1'b1, 1'b0, 1'b0, "rand"};
    vecs[4] = '{3, 2, 1'b1, 1'b1, 1'b1, "rand_ovf"};
    set_mem(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl",
          {src_rd_en, filt_valid, filt_more_pixels, dst_wr_en,
           busy, frame_done, err_overflow}, 0);
    check("rst_addr", {src_addr, dst_addr}, 0);
    check("rst_data", {filt_pixel, dst_wr_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);

    foreach (vecs[k]) begin
      stall_pix = vecs[k].stall_pix;
      stall_len = vecs[k].stall_len;
      rnd_stall = vecs[k].rnd;
      extra_en  = vecs[k].extra;
      set_mem(vecs[k].rnd);
      launch(vecs[k].name);
      finish_frame(vecs[k].name, vecs[k].exp_err);
    end

    stall_pix = -1;
    stall_len = 0;
    rnd_stall = 1'b0;
    extra_en  = 1'b0;
    set_mem(1'b0);

    // start while busy is ignored
    launch("busy_start");
    wait_cond("busy_start", 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_frame("busy_start", 1'b0);

    // abort at pixel 20, then a clean restart
    launch("abort");
    wait_cond("abort", 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_outs",
          {filt_valid, filt_more_pixels, busy, src_rd_en}, 4'b0000);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    launch("restart");
    finish_frame("restart", 1'b0);

    // start together with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", {busy, src_rd_en, filt_more_pixels}, 3'b000);

    // reset pulse during DRAIN
    launch("drain_rst");
    wait_cond("drain_rst", 2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ctl",
          {src_rd_en, filt_valid, filt_more_pixels, dst_wr_en,
           busy, frame_done, err_overflow}, 0);
    check("async_rst_addr", {src_addr, dst_addr}, 0);
    check("async_rst_data", {filt_pixel, dst_wr_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt, 0);
    launch("post_rst");
    finish_frame("post_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
